// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issue/retire controller: opcodes, FP32 field layout and flag decoding.
`timescale 1ns/1ps
package fpu_pkg;

  localparam logic [1:0] FPU_OP_ADD = 2'b00;
  localparam logic [1:0] FPU_OP_SUB = 2'b01;
  localparam logic [1:0] FPU_OP_MUL = 2'b10;
  localparam logic [1:0] FPU_OP_DIV = 2'b11;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  // Bit positions inside the 4-bit {nan, inf, zero, denorm} flag word
  localparam int FLAG_NAN    = 3;
  localparam int FLAG_INF    = 2;
  localparam int FLAG_ZERO   = 1;
  localparam int FLAG_DENORM = 0;

  function automatic logic [3:0] fp32_flags(input logic [31:0] x);
    logic [FP32_EXP_W-1:0] exp_f;
    logic [FP32_MAN_W-1:0] man_f;
    logic [3:0]            f;
    exp_f = x[FP32_MAN_W +: FP32_EXP_W];
    man_f = x[FP32_MAN_W-1:0];
    f = '0;
    f[FLAG_NAN]    = (&exp_f) && (|man_f);
    f[FLAG_INF]    = (&exp_f) && !(|man_f);
    f[FLAG_ZERO]   = !(|exp_f) && !(|man_f);
    f[FLAG_DENORM] = !(|exp_f) && (|man_f);
    return f;
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Request, response and fpu-facing signals of fpu_issue_ctrl; slave is the controller, master the environment.
`timescale 1ns/1ps
interface fpu_issue_ctrl_if #(parameter int TAG_W = 4);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      fpu_a;
  logic [31:0]      fpu_b;
  logic [1:0]       fpu_opcode;
  logic [31:0]      fpu_o;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_tag, fpu_o, out_ready,
    output in_ready, fpu_a, fpu_b, fpu_opcode, out_valid, out_data, out_tag, out_flags
  );

  modport master (
    output in_valid, in_a, in_b, in_op, in_tag, fpu_o, out_ready,
    input  in_ready, fpu_a, fpu_b, fpu_opcode, out_valid, out_data, out_tag, out_flags
  );
endinterface

// File: rtl/fpu_res_fifo.sv
// Synchronous result FIFO with registered read data; the head entry stays counted until it is popped.
`timescale 1ns/1ps
module fpu_res_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic             pop;

  assign pop        = rd_valid && rd_ready;
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);

  // NOTE: storage is left out of reset; pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Head register reloads from the entry that will be at the head after this edge's pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr_nxt;
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      if (count != CNT_W'(pop)) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_ptr_nxt];
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push |-> (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/retire controller wrapping a fixed-latency fpu with credit-based back-pressure and a result FIFO.
// Optional macro FPU_ISSUE_FLAGS_EN stores {nan, inf, zero, denorm} flags per result entry.
`timescale 1ns/1ps
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int FPU_LAT   = 2,
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input logic              clk,
  input logic              rst,
  fpu_issue_ctrl_if.slave  bus
);
  localparam int CNT_W = $clog2(RES_DEPTH+1);
`ifdef FPU_ISSUE_FLAGS_EN
  localparam int ENT_W = 4 + TAG_W + 32;
`else
  localparam int ENT_W = TAG_W + 32;
`endif

  logic [31:0]      fpu_a_q, fpu_b_q;
  logic [1:0]       fpu_op_q;
  logic [FPU_LAT:0] trk_vld;
  logic [TAG_W-1:0] trk_tag [FPU_LAT+1];
  logic [CNT_W-1:0] inflight_cnt, fifo_cnt;
  logic             accept, retire;
  logic [ENT_W-1:0] push_data, head;

  assign accept = bus.in_valid && bus.in_ready;
  assign retire = trk_vld[FPU_LAT];

  // Credit covers every op between accept and pop, so the FIFO can always absorb a retiring result
  assign bus.in_ready = !rst &&
    (({1'b0, fifo_cnt} + {1'b0, inflight_cnt}) < (CNT_W+1)'(RES_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      fpu_op_q     <= FPU_OP_ADD;
      trk_vld      <= '0;
      inflight_cnt <= '0;
    end else begin
      if (accept) begin
        fpu_a_q  <= bus.in_a;
        fpu_b_q  <= bus.in_b;
        fpu_op_q <= bus.in_op;
      end
      trk_vld <= {trk_vld[FPU_LAT-1:0], accept};
      case ({accept, retire})
        2'b10:   inflight_cnt <= inflight_cnt + CNT_W'(1);
        2'b01:   inflight_cnt <= inflight_cnt - CNT_W'(1);
        default: inflight_cnt <= inflight_cnt;
      endcase
    end
  end

  // Tags travel alongside the valid bits and only matter where trk_vld is set
  always_ff @(posedge clk) begin
    trk_tag[0] <= bus.in_tag;
    for (int i = 1; i <= FPU_LAT; i++) trk_tag[i] <= trk_tag[i-1];
  end

  assign bus.fpu_a      = fpu_a_q;
  assign bus.fpu_b      = fpu_b_q;
  assign bus.fpu_opcode = fpu_op_q;

`ifdef FPU_ISSUE_FLAGS_EN
  assign push_data     = {fp32_flags(bus.fpu_o), trk_tag[FPU_LAT], bus.fpu_o};
  assign bus.out_flags = head[ENT_W-1 -: 4];
`else
  assign push_data     = {trk_tag[FPU_LAT], bus.fpu_o};
  assign bus.out_flags = 4'b0000;
`endif
  assign bus.out_data = head[31:0];
  assign bus.out_tag  = head[32 +: TAG_W];

  fpu_res_fifo #(.WIDTH(ENT_W), .DEPTH(RES_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (retire),
    .push_data (push_data),
    .rd_ready  (bus.out_ready),
    .rd_valid  (bus.out_valid),
    .rd_data   (head),
    .count     (fifo_cnt)
  );

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: stub fpu, accept monitor feeding a queue, output monitor checking it.
`timescale 1ns/1ps
module tb_fpu_issue_ctrl;
  import fpu_pkg::*;

  localparam int FPU_LAT   = 2;
  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 4;
  localparam int LAT       = FPU_LAT + 2;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic [3:0]       flags;
    int               acc_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  int   outstanding = 0;
  int   acc_total = 0;
  logic [31:0] exp_fa = '0, exp_fb = '0;
  logic [1:0]  exp_fop = '0;
  logic        shown = 1'b0;
  int          first_seen = 0;
  int          last_pop = 0;
  logic [39:0] seen = '0;
  logic [31:0] last_d = '0;
  logic [TAG_W-1:0] last_t = '0;
  logic [3:0]  last_f = '0;
  exp_t        e_acc, e_out;
  logic        rand_phase = 1'b0;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpu_issue_ctrl #(.FPU_LAT(FPU_LAT), .RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Stand-in fpu: known ADD results for the directed vectors, x+0=x, otherwise an arbitrary mix
  function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (op == FPU_OP_ADD) begin
      if (a == 32'h71E3A159 && b == 32'hF24CABEF) return 32'hF1B5B685;
      if (a == 32'hC2342E41 && b == 32'h2E3C8F5C) return 32'hC2342E41;
      if (a == 32'h367329EC && b == 32'h51ABA17E) return 32'h51ABA17E;
      if (a == 32'h7F800000 && b == 32'h3F800000) return 32'h7F800000;
      if (b == 32'h0) return a;
    end
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op} ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [3:0] exp_flags(input logic [31:0] d);
`ifdef FPU_ISSUE_FLAGS_EN
    logic [7:0]  ex;
    logic [22:0] mn;
    ex = d[30:23];
    mn = d[22:0];
    if (ex == 8'hFF) return (mn != 0) ? 4'b1000 : 4'b0100;
    if (ex == 8'h00) return (mn == 0) ? 4'b0010 : 4'b0001;
    return 4'b0000;
`else
    return 4'b0000;
`endif
  endfunction

  logic [31:0] fpu_pipe [FPU_LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_ref(bus.fpu_a, bus.fpu_b, bus.fpu_opcode);
    for (int i = 1; i < FPU_LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign bus.fpu_o = fpu_pipe[FPU_LAT-1];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept side: credit model and issue registers, pushes expected results
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_rst", bus.in_ready, 1'b0);
      sb_q.delete();
      outstanding = 0;
      exp_fa = '0; exp_fb = '0; exp_fop = FPU_OP_ADD;
    end else begin
      check("in_ready", bus.in_ready, outstanding < RES_DEPTH);
      check("fpu_issue", {bus.fpu_a, bus.fpu_b, bus.fpu_opcode}, {exp_fa, exp_fb, exp_fop});
      if (bus.in_valid && bus.in_ready) begin
        e_acc.data     = fpu_ref(bus.in_a, bus.in_b, bus.in_op);
        e_acc.tag      = bus.in_tag;
        e_acc.flags    = exp_flags(e_acc.data);
        e_acc.acc_edge = cyc + 1;
        sb_q.push_back(e_acc);
        outstanding++;
        acc_total++;
        exp_fa = bus.in_a; exp_fb = bus.in_b; exp_fop = bus.in_op;
      end
      if (bus.out_valid && bus.out_ready) outstanding--;
    end
  end

  // Output side: order, content, presentation cycle, stability and hold-when-empty
  always @(negedge clk) begin
    if (rst) begin
      shown = 1'b0;
      last_d = '0; last_t = '0; last_f = '0;
    end else if (bus.out_valid) begin
      if (!shown) begin
        shown = 1'b1;
        first_seen = cyc;
        seen = {bus.out_flags, bus.out_tag, bus.out_data};
      end else begin
        check("out_stable", {bus.out_flags, bus.out_tag, bus.out_data}, seen);
      end
      if (bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got data %0h tag %0h with nothing outstanding (cycle %0d)",
                   bus.out_data, bus.out_tag, cyc);
        end else begin
          e_out = sb_q.pop_front();
          check("out_data", bus.out_data, e_out.data);
          check("out_tag", bus.out_tag, e_out.tag);
          check("out_flags", bus.out_flags, e_out.flags);
          check("out_cycle", first_seen,
                (e_out.acc_edge + LAT > last_pop + 1) ? e_out.acc_edge + LAT : last_pop + 1);
        end
        last_pop = cyc;
        last_d = bus.out_data; last_t = bus.out_tag; last_f = bus.out_flags;
        shown = 1'b0;
      end
    end else begin
      check("out_hold", {bus.out_flags, bus.out_tag, bus.out_data}, {last_f, last_t, last_d});
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [TAG_W-1:0] tag);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_tag = tag;
    do begin @(negedge clk); waited++; end while (!bus.in_ready && waited < 200);
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got no in_ready within %0d cycles", waited);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb_q.size());
    end
    idle(2);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return 32'h7F800000;
      1:       return 32'h7FC00001;
      2:       return 32'h00000005;
      3:       return 32'h00000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int mark;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.in_tag = '0;
    bus.out_ready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single ADD, empty FIFO
    send(32'h71E3A159, 32'hF24CABEF, FPU_OP_ADD, 4'd5);
    drain();
    check("add_result", last_d, 32'hF1B5B685);

    // Back-to-back ADDs, tags 0..3
    send(32'h3F800000, 32'h40000000, FPU_OP_ADD, 4'd0);
    send(32'hC2342E41, 32'h2E3C8F5C, FPU_OP_ADD, 4'd1);
    send(32'h12345678, 32'h00000000, FPU_OP_ADD, 4'd2);
    send(32'h40490FDB, 32'hBF800000, FPU_OP_ADD, 4'd3);
    drain();

    // Stalled consumer: credit caps accepts at RES_DEPTH
    bus.out_ready = 1'b0;
    mark = acc_total;
    fork
      begin
        for (int i = 0; i < 6; i++) send($urandom, $urandom, 2'($urandom_range(0, 3)), 4'(8 + i));
      end
      begin
        idle(20);
        check("credit_accepts", acc_total - mark, RES_DEPTH);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Pop coincides with a retire while two results sit in the FIFO
    bus.out_ready = 1'b0;
    send(32'h11111111, 32'h22222222, FPU_OP_MUL, 4'd1);
    send(32'h33333333, 32'h44444444, FPU_OP_SUB, 4'd2);
    send(32'h55555555, 32'h66666666, FPU_OP_DIV, 4'd3);
    idle(2);
    bus.out_ready = 1'b1;
    drain();

    // Reset with two ops in flight, then a fresh ADD
    send(32'hAAAA0000, 32'h0000BBBB, FPU_OP_ADD, 4'd6);
    send(32'hCCCC0000, 32'h0000DDDD, FPU_OP_MUL, 4'd7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(10);
    send(32'h367329EC, 32'h51ABA17E, FPU_OP_ADD, 4'd9);
    drain();
    check("add_after_rst", last_d, 32'h51ABA17E);

    // Infinity result flags
    send(32'h7F800000, 32'h3F800000, FPU_OP_ADD, 4'd4);
    drain();
`ifdef FPU_ISSUE_FLAGS_EN
    check("inf_flags", last_f, 4'b0100);
`else
    check("inf_flags", last_f, 4'b0000);
`endif

    // Random traffic with a randomly stalling consumer
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          send(pick_operand(), ($urandom_range(0, 3) == 0) ? 32'h0 : pick_operand(),
               2'($urandom_range(0, 3)), 4'($urandom));
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
